// File: rtl/td4_sequencer_if.sv
// ---------------------------------------------------------------------------
// td4_sequencer_if
//   Bus between the TD4 sequencer and the datapath it controls (program ROM,
//   PC register, A/B/OUT registers, ALU).
//
//   PC_IN     datapath -> sequencer   current program counter
//   ROM_ADDR  sequencer -> ROM        program ROM address
//   ROM_DATA  ROM -> sequencer        combinational ROM read data
//   C_FLAG    datapath -> sequencer   carry from the previous ADD
//   REG_EN    sequencer -> datapath   register-bank / PC clock enable
//   LOAD_*_N  sequencer -> datapath   active-low load strobes (A, B, OUT, PC)
//   SEL       sequencer -> ALU        operand select (A, B, IN port, zero)
//   IM        sequencer -> ALU        immediate operand
//
//   master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface td4_sequencer_if #(
  parameter int IMM_W = 4
);
  logic [IMM_W-1:0] PC_IN;
  logic [IMM_W-1:0] ROM_ADDR;
  logic [7:0]       ROM_DATA;
  logic             C_FLAG;
  logic             REG_EN;
  logic             LOAD_A_N;
  logic             LOAD_B_N;
  logic             LOAD_OUT_N;
  logic             LOAD_PC_N;
  logic [1:0]       SEL;
  logic [IMM_W-1:0] IM;

  modport master (
    input  PC_IN, ROM_DATA, C_FLAG,
    output ROM_ADDR, REG_EN, LOAD_A_N, LOAD_B_N, LOAD_OUT_N, LOAD_PC_N, SEL, IM
  );

  modport slave (
    output PC_IN, ROM_DATA, C_FLAG,
    input  ROM_ADDR, REG_EN, LOAD_A_N, LOAD_B_N, LOAD_OUT_N, LOAD_PC_N, SEL, IM
  );
endinterface

// File: rtl/td4_sequencer.sv
// ---------------------------------------------------------------------------
// td4_sequencer
//   Fetch/decode/control stage of the TD4 CPU. Each instruction takes two
//   cycles: FETCH reads ROM at PC_IN into the instruction register, EXEC
//   presents the decoded strobes with REG_EN high so the datapath updates on
//   the edge that ends EXEC. Adds run/step control, jump-to-self halt
//   detection and sticky illegal-opcode flagging.
//
//   CLK      clock, rising edge
//   CLR      asynchronous active-low reset
//   RUN      1 = fetch continuously, 0 = stop after the current instruction
//   bus      td4_sequencer_if.master (ROM, PC, strobes, SEL, IM)
//   HALT     sticky: a jump-to-self was executed
//   ILLEGAL  sticky: an illegal opcode was fetched
//   STATE    FSM debug view: 00 IDLE, 01 FETCH, 10 EXEC, 11 HALT
// ---------------------------------------------------------------------------
module td4_sequencer #(
  parameter int IMM_W       = 4,
  parameter bit HALT_DETECT = 1'b1
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            RUN,
  td4_sequencer_if.master bus,
  output logic            HALT,
  output logic            ILLEGAL,
  output logic [1:0]      STATE
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  logic [1:0]       state, state_nxt;
  logic [7:0]       ir;          // instruction register
  logic             carry;       // C_FLAG captured with the instruction
  logic             halt_pend;   // current instruction is a jump-to-self
  logic             ill;         // sticky illegal flag
  logic [IMM_W-1:0] rom_addr_q;  // ROM address held outside FETCH

  logic             is_fetch, is_exec;
  logic [3:0]       fetch_op, fetch_im;
  logic             fetch_illegal;

  assign is_fetch      = (state == S_FETCH);
  assign is_exec       = (state == S_EXEC);
  assign fetch_op      = bus.ROM_DATA[7:4];
  assign fetch_im      = bus.ROM_DATA[3:0];
  assign fetch_illegal = (fetch_op == 4'h8) || (fetch_op == 4'hA) ||
                         (fetch_op == 4'hC) || (fetch_op == 4'hD);

  // HALT only leaves through CLR, so it simply holds here.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (RUN) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  begin
        if (halt_pend)  state_nxt = S_HALT;
        else if (RUN)   state_nxt = S_FETCH;
        else            state_nxt = S_IDLE;
      end
      default: state_nxt = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= S_IDLE;
      ir         <= 8'h00;
      carry      <= 1'b0;
      halt_pend  <= 1'b0;
      ill        <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (is_fetch) begin
        ir         <= bus.ROM_DATA;
        carry      <= bus.C_FLAG;
        rom_addr_q <= bus.PC_IN;
        // Only an unconditional JMP to its own address halts; JNC to self
        // may fall through and is therefore not a halt.
        halt_pend  <= HALT_DETECT && (fetch_op == 4'hF) &&
                      (IMM_W'(fetch_im) == bus.PC_IN);
        if (fetch_illegal) ill <= 1'b1;
      end
    end
  end

  assign bus.ROM_ADDR = is_fetch ? bus.PC_IN : rom_addr_q;

  // Decode straight from the instruction register: IR only changes at the
  // end of FETCH, so SEL/IM hold outside EXEC for free, and IR = 00 after
  // reset decodes to SEL = 00, IM = 0.
  logic             ld_a, ld_b, ld_out, ld_pc;
  logic [1:0]       sel;
  logic [IMM_W-1:0] imm;
  logic [IMM_W-1:0] ir_im;

  assign ir_im = IMM_W'(ir[3:0]);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    ld_pc  = 1'b0;
    sel    = 2'b11;
    imm    = '0;
    case (ir[7:4])
      4'h0: begin ld_a   = 1'b1; sel = 2'b00; imm = ir_im; end  // ADD A,Im
      4'h5: begin ld_b   = 1'b1; sel = 2'b01; imm = ir_im; end  // ADD B,Im
      4'h3: begin ld_a   = 1'b1; sel = 2'b11; imm = ir_im; end  // MOV A,Im
      4'h7: begin ld_b   = 1'b1; sel = 2'b11; imm = ir_im; end  // MOV B,Im
      4'h1: begin ld_a   = 1'b1; sel = 2'b01;              end  // MOV A,B
      4'h4: begin ld_b   = 1'b1; sel = 2'b00;              end  // MOV B,A
      4'h2: begin ld_a   = 1'b1; sel = 2'b10;              end  // IN A
      4'h6: begin ld_b   = 1'b1; sel = 2'b10;              end  // IN B
      4'h9: begin ld_out = 1'b1; sel = 2'b01;              end  // OUT B
      4'hB: begin ld_out = 1'b1; sel = 2'b11; imm = ir_im; end  // OUT Im
      4'hF: begin ld_pc  = 1'b1; sel = 2'b11; imm = ir_im; end  // JMP
      4'hE: begin ld_pc  = ~carry; sel = 2'b11; imm = ir_im; end  // JNC
      default: ;  // illegal: NOP, PC still increments via REG_EN
    endcase
  end

  assign bus.REG_EN     = is_exec;
  assign bus.LOAD_A_N   = ~(is_exec & ld_a);
  assign bus.LOAD_B_N   = ~(is_exec & ld_b);
  assign bus.LOAD_OUT_N = ~(is_exec & ld_out);
  assign bus.LOAD_PC_N  = ~(is_exec & ld_pc);
  assign bus.SEL        = sel;
  assign bus.IM         = imm;

  assign HALT    = (state == S_HALT);
  assign ILLEGAL = ill;
  assign STATE   = state;

endmodule
